// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pc_sequencer
// Brief    : Program-counter sequencer with increment, skip, absolute load,
//            subroutine call/return through a circular hardware return stack,
//            and a halt input that freezes all state.
//            Optional macro PC_STACK_GUARD_EN: block call on full / ret on
//            empty and raise a sticky stack_err; otherwise the stack wraps.
// Revision : 1.0  initial release
// ============================================================================
module pc_sequencer #(
    parameter int PC_W        = 5,
    parameter int STACK_DEPTH = 4,
    parameter int RESET_VEC   = 0
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               halt,
    input  logic                               load,
    input  logic [PC_W-1:0]                    load_val,
    input  logic                               inc_pc,
    input  logic                               skip,
    input  logic                               call,
    input  logic [PC_W-1:0]                    call_target,
    input  logic                               ret,
    output logic [PC_W-1:0]                    pc,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   stack_count,
    output logic                               stack_empty,
    output logic                               stack_full,
    output logic                               stack_err
);

    localparam int c_PTR_W = $clog2(STACK_DEPTH);
    localparam int c_CNT_W = $clog2(STACK_DEPTH+1);
    localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(STACK_DEPTH);
    localparam logic [PC_W-1:0]    c_PC_RST   = PC_W'(RESET_VEC);

    logic [PC_W-1:0]    r_pc;
    logic [c_PTR_W-1:0] r_ptr;        // next free slot; top entry is r_ptr-1
    logic [c_CNT_W-1:0] r_count;
    logic [PC_W-1:0]    r_stack [STACK_DEPTH];

    logic [PC_W-1:0]    w_pc_inc;
    logic [PC_W-1:0]    w_pc_skip;
    logic [c_PTR_W-1:0] w_top_idx;
    logic               w_empty;
    logic               w_full;
    logic               w_ret_blocked;
    logic               w_call_blocked;
    logic               w_do_push;

    // Modulo-2^PC_W successors; the pushed return address wraps the same way
    assign w_pc_inc  = r_pc + PC_W'(1);
    assign w_pc_skip = r_pc + PC_W'(2);
    assign w_top_idx = r_ptr - c_PTR_W'(1);

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_CNT_FULL);

`ifdef PC_STACK_GUARD_EN
    assign w_ret_blocked  = w_empty;
    assign w_call_blocked = w_full;
`else
    assign w_ret_blocked  = 1'b0;
    assign w_call_blocked = 1'b0;
`endif

    // A call only writes the stack when it is the winning command and not blocked
    assign w_do_push = !halt && !ret && call && !w_call_blocked;

    // PC, stack pointer and occupancy count, with halt > ret > call > load > skip > inc
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc    <= c_PC_RST;
            r_ptr   <= '0;
            r_count <= '0;
        end else if (halt) begin
            r_pc    <= r_pc;
        end else if (ret) begin
            // A blocked ret consumes the cycle without falling through
            if (!w_ret_blocked) begin
                r_pc  <= r_stack[w_top_idx];
                r_ptr <= w_top_idx;
                if (!w_empty) begin
                    r_count <= r_count - c_CNT_W'(1);
                end
            end
        end else if (call) begin
            if (!w_call_blocked) begin
                r_pc  <= call_target;
                r_ptr <= r_ptr + c_PTR_W'(1);
                if (!w_full) begin
                    r_count <= r_count + c_CNT_W'(1);
                end
            end
        end else if (load) begin
            r_pc <= load_val;
        end else if (skip) begin
            r_pc <= w_pc_skip;
        end else if (inc_pc) begin
            r_pc <= w_pc_inc;
        end
    end

    // Return-address storage; left unreset, contents are defined only once written
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_stack[r_ptr] <= w_pc_inc;
        end
    end

`ifdef PC_STACK_GUARD_EN
    logic r_err;

    // Sticky error on any blocked call or ret; only reset clears it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (!halt && ((ret && w_ret_blocked) ||
                               (!ret && call && w_call_blocked))) begin
            r_err <= 1'b1;
        end
    end

    assign stack_err = r_err;
`else
    assign stack_err = 1'b0;
`endif

    assign pc          = r_pc;
    assign stack_count = r_count;
    assign stack_empty = w_empty;
    assign stack_full  = w_full;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_sequencer
// Brief    : Self-checking bench for pc_sequencer: directed scenarios plus a
//            randomized run compared against a queue-based reference model.
//            Honors PC_STACK_GUARD_EN the same way the design does.
// Revision : 1.0  initial release
// ============================================================================
module tb_pc_sequencer;

    localparam int PC_W  = 5;
    localparam int DEPTH = 4;
    localparam int RV    = 3;
    localparam int CW    = $clog2(DEPTH+1);
`ifdef PC_STACK_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            halt, load, inc_pc, skip, call, ret;
    logic [PC_W-1:0] load_val, call_target;
    logic [PC_W-1:0] pc;
    logic [CW-1:0]   stack_count;
    logic            stack_empty, stack_full, stack_err;

    int checks = 0;
    int errors = 0;

    // Reference model: pc value, LIFO of return addresses, sticky error
    logic [PC_W-1:0] mpc;
    logic [PC_W-1:0] mq[$];
    logic            merr;

    pc_sequencer #(.PC_W(PC_W), .STACK_DEPTH(DEPTH), .RESET_VEC(RV)) dut (
        .clk(clk), .rst(rst), .halt(halt), .load(load), .load_val(load_val),
        .inc_pc(inc_pc), .skip(skip), .call(call), .call_target(call_target),
        .ret(ret), .pc(pc), .stack_count(stack_count),
        .stack_empty(stack_empty), .stack_full(stack_full),
        .stack_err(stack_err)
    );

    always #5 clk = ~clk;

    task automatic clear_in;
        halt = 0; load = 0; inc_pc = 0; skip = 0; call = 0; ret = 0;
        load_val = '0; call_target = '0;
    endtask

    // Advance the model by one command using the currently driven strobes
    task automatic model_step;
        if (halt) begin
        end else if (ret) begin
            if (mq.size() == 0) begin
                if (GUARD) merr = 1'b1;
            end else begin
                mpc = mq.pop_back();
            end
        end else if (call) begin
            if (mq.size() == DEPTH && GUARD) begin
                merr = 1'b1;
            end else begin
                if (mq.size() == DEPTH) void'(mq.pop_front());
                mq.push_back(PC_W'(mpc + 1));
                mpc = call_target;
            end
        end else if (load) begin
            mpc = load_val;
        end else if (skip) begin
            mpc = PC_W'(mpc + 2);
        end else if (inc_pc) begin
            mpc = PC_W'(mpc + 1);
        end
    endtask

    // Drive one command, let it clock in, sample 1 ns after the edge
    task automatic apply(input logic h, r, c, l, s, i,
                         input logic [PC_W-1:0] lv, ct);
        halt = h; ret = r; call = c; load = l; skip = s; inc_pc = i;
        load_val = lv; call_target = ct;
        model_step();
        @(posedge clk);
        #1;
        clear_in();
    endtask

    task automatic do_reset;
        rst = 1'b1;
        mpc = PC_W'(RV); mq.delete(); merr = 1'b0;
        #2;
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #1;
        checks++;
        if (pc !== PC_W'(RV) || stack_count !== '0 || stack_empty !== 1'b1 ||
            stack_full !== 1'b0 || stack_err !== 1'b0) begin
            errors++;
            $display("FAIL reset: pc=%0d cnt=%0d e=%b f=%b err=%b, want pc=%0d cnt=0 e=1 f=0 err=0",
                     pc, stack_count, stack_empty, stack_full, stack_err, RV);
        end
        #1;
        rst = 1'b0;
        mpc = PC_W'(RV); mq.delete(); merr = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            apply(0, 0, 0, 0, 0, 1, '0, '0);
            checks++;
            if (pc !== PC_W'(RV + k) || stack_empty !== 1'b1 || stack_err !== 1'b0) begin
                errors++;
                $display("FAIL inc_%0d: pc=%0d e=%b err=%b, want pc=%0d e=1 err=0",
                         k, pc, stack_empty, stack_err, RV + k);
            end
        end
    endtask

    task automatic test_wrap_skip;
        logic [PC_W-1:0] want [4];
        want = '{5'd30, 5'd0, 5'd0, 5'd1};
        apply(0, 0, 0, 1, 0, 0, 5'd30, '0);
        checks++;
        if (pc !== want[0]) begin errors++; $display("FAIL load30: pc=%0d want %0d", pc, want[0]); end
        apply(0, 0, 0, 0, 1, 0, '0, '0);
        checks++;
        if (pc !== want[1]) begin errors++; $display("FAIL skip30: pc=%0d want %0d", pc, want[1]); end
        apply(0, 0, 0, 1, 0, 0, 5'd31, '0);
        apply(0, 0, 0, 0, 0, 1, '0, '0);
        checks++;
        if (pc !== want[2]) begin errors++; $display("FAIL inc31: pc=%0d want %0d", pc, want[2]); end
        apply(0, 0, 0, 1, 0, 0, 5'd31, '0);
        apply(0, 0, 0, 0, 1, 0, '0, '0);
        checks++;
        if (pc !== want[3]) begin errors++; $display("FAIL skip31: pc=%0d want %0d", pc, want[3]); end
    endtask

    task automatic test_priority;
        apply(0, 0, 0, 1, 0, 0, 5'd4, '0);
        apply(0, 0, 0, 1, 1, 1, 5'd9, '0);
        checks++;
        if (pc !== 5'd9) begin errors++; $display("FAIL prio_load: pc=%0d want 9", pc); end
        apply(0, 0, 0, 1, 0, 0, 5'd4, '0);
        apply(1, 0, 0, 1, 1, 1, 5'd9, '0);
        checks++;
        if (pc !== 5'd4) begin errors++; $display("FAIL prio_halt: pc=%0d want 4", pc); end
    endtask

    task automatic test_nested_call;
        logic [PC_W-1:0] wpc [4];
        logic [CW-1:0]   wcnt [4];
        wpc  = '{5'd10, 5'd20, 5'd11, 5'd3};
        wcnt = '{3'd1, 3'd2, 3'd1, 3'd0};
        do_reset();
        apply(0, 0, 0, 1, 0, 0, 5'd2, '0);
        for (int k = 0; k < 4; k++) begin
            if (k < 2) apply(0, 0, 1, 0, 0, 0, '0, (k == 0) ? 5'd10 : 5'd20);
            else       apply(0, 1, 0, 0, 0, 0, '0, '0);
            checks++;
            if (pc !== wpc[k] || stack_count !== wcnt[k]) begin
                errors++;
                $display("FAIL nested_%0d: pc=%0d cnt=%0d want pc=%0d cnt=%0d",
                         k, pc, stack_count, wpc[k], wcnt[k]);
            end
        end
        checks++;
        if (stack_empty !== 1'b1) begin errors++; $display("FAIL nested_empty: e=%b want 1", stack_empty); end
    endtask

    task automatic test_back_to_back;
        apply(0, 0, 0, 1, 0, 0, 5'd7, '0);
        apply(0, 0, 1, 0, 0, 0, '0, 5'd15);
        apply(0, 1, 0, 0, 0, 0, '0, '0);
        checks++;
        if (pc !== 5'd8 || stack_count !== '0) begin
            errors++;
            $display("FAIL b2b: pc=%0d cnt=%0d want pc=8 cnt=0", pc, stack_count);
        end
    endtask

    task automatic test_overflow;
        logic [PC_W-1:0] wret [4];
        do_reset();
        apply(0, 0, 0, 1, 0, 0, 5'd0, '0);
        // Return addresses pushed: 1, 9, 10, 11, then 12 from the 5th call
        for (int k = 0; k < 5; k++) apply(0, 0, 1, 0, 0, 0, '0, PC_W'(8 + k));
        checks++;
        if (GUARD) begin
            if (pc !== 5'd11 || stack_count !== 3'd4 || stack_full !== 1'b1 || stack_err !== 1'b1) begin
                errors++;
                $display("FAIL ovf_guard: pc=%0d cnt=%0d f=%b err=%b want pc=11 cnt=4 f=1 err=1",
                         pc, stack_count, stack_full, stack_err);
            end
            wret = '{5'd11, 5'd10, 5'd9, 5'd1};
        end else begin
            if (pc !== 5'd12 || stack_count !== 3'd4 || stack_full !== 1'b1 || stack_err !== 1'b0) begin
                errors++;
                $display("FAIL ovf_wrap: pc=%0d cnt=%0d f=%b err=%b want pc=12 cnt=4 f=1 err=0",
                         pc, stack_count, stack_full, stack_err);
            end
            wret = '{5'd12, 5'd11, 5'd10, 5'd9};
        end
        for (int k = 0; k < 4; k++) begin
            apply(0, 1, 0, 0, 0, 0, '0, '0);
            checks++;
            if (pc !== wret[k] || stack_count !== CW'(3 - k)) begin
                errors++;
                $display("FAIL ovf_ret_%0d: pc=%0d cnt=%0d want pc=%0d cnt=%0d",
                         k, pc, stack_count, wret[k], 3 - k);
            end
        end
    endtask

    task automatic test_async_reset;
        do_reset();
        apply(0, 0, 0, 1, 0, 0, 5'd5, '0);
        apply(0, 0, 1, 0, 0, 0, '0, 5'd10);
        call = 1'b1; call_target = 5'd20;
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (pc !== PC_W'(RV) || stack_count !== '0 || stack_empty !== 1'b1) begin
            errors++;
            $display("FAIL async_rst: pc=%0d cnt=%0d e=%b want pc=%0d cnt=0 e=1",
                     pc, stack_count, stack_empty, RV);
        end
        #1;
        rst = 1'b0;
        clear_in();
        mpc = PC_W'(RV); mq.delete(); merr = 1'b0;
        if (GUARD) begin
            apply(0, 1, 0, 0, 0, 0, '0, '0);
            checks++;
            if (pc !== PC_W'(RV) || stack_err !== 1'b1 || stack_count !== '0) begin
                errors++;
                $display("FAIL ret_empty_guard: pc=%0d err=%b cnt=%0d want pc=%0d err=1 cnt=0",
                         pc, stack_err, stack_count, RV);
            end
            apply(0, 0, 0, 0, 0, 1, '0, '0);
            checks++;
            if (stack_err !== 1'b1) begin errors++; $display("FAIL err_sticky: err=%b want 1", stack_err); end
        end else begin
            apply(0, 0, 0, 0, 0, 1, '0, '0);
            checks++;
            if (pc !== PC_W'(RV + 1) || stack_err !== 1'b0) begin
                errors++;
                $display("FAIL post_rst_inc: pc=%0d err=%b want pc=%0d err=0", pc, stack_err, RV + 1);
            end
        end
    endtask

    task automatic test_random;
        logic h, r, c, l, s, i;
        do_reset();
        for (int n = 0; n < 500; n++) begin
            h = ($urandom_range(0, 9) == 0);
            r = ($urandom_range(0, 3) == 0);
            c = ($urandom_range(0, 2) == 0);
            l = ($urandom_range(0, 5) == 0);
            s = $urandom_range(0, 1);
            i = $urandom_range(0, 1);
            // Popping an empty wrapping stack yields stale data; keep it out of the run
            if (!GUARD && mq.size() == 0) r = 1'b0;
            apply(h, r, c, l, s, i, PC_W'($urandom), PC_W'($urandom));
            checks++;
            if (pc !== mpc || stack_count !== CW'(mq.size()) ||
                stack_empty !== (mq.size() == 0) || stack_full !== (mq.size() == DEPTH) ||
                stack_err !== merr) begin
                errors++;
                $display("FAIL rand_%0d: pc=%0d cnt=%0d e=%b f=%b err=%b want pc=%0d cnt=%0d err=%b",
                         n, pc, stack_count, stack_empty, stack_full, stack_err,
                         mpc, mq.size(), merr);
            end
        end
    endtask

    initial begin
        clear_in();
        rst = 1'b0;
        #2;
        test_reset();
        test_wrap_skip();
        test_priority();
        test_nested_call();
        test_back_to_back();
        test_overflow();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer for the RISC CPU: holds the fetch address and advances it by increment, skip, absolute load, subroutine call and return. Successor to the fixed 5-bit counter: generalised address width, a hardware return-address stack of configurable depth, a halt/freeze input and explicit command priority. Sits between the control FSM, which drives the command strobes, and the instruction memory address port.

## Interface
Parameters:
- PC_W, 5, address width in bits (>= 2)
- STACK_DEPTH, 4, return-stack entries; power of two, >= 2
- RESET_VEC, 0, value loaded into pc on reset (PC_W bits)

Ports:
- clk  in  1  system clock, rising-edge
- rst  in  1  asynchronous, active-high reset
- halt  in  1  freeze pc and stack while high
- load  in  1  absolute jump strobe
- load_val  in  PC_W  jump target
- inc_pc  in  1  advance pc by 1
- skip  in  1  advance pc by 2
- call  in  1  push return address, jump to call_target
- call_target  in  PC_W  subroutine entry address
- ret  in  1  pop return address into pc
- pc  out  PC_W  current fetch address (registered)
- stack_count  out  $clog2(STACK_DEPTH+1)  valid entries on stack
- stack_empty  out  1  stack_count == 0
- stack_full  out  1  stack_count == STACK_DEPTH
- stack_err  out  1  sticky overflow/underflow flag (see Configuration)

## Operation
- One command executes per cycle; fixed priority: halt > ret > call > load > skip > inc_pc. Lower-priority strobes asserted in the same cycle are ignored and not retained.
- halt: pc, stack contents, pointer, count and stack_err all hold.
- ret: pc <= top entry; pointer decrements; count decrements.
- call: top <= pc + 1 (mod 2^PC_W); pc <= call_target; pointer increments; count increments.
- load: pc <= load_val. skip: pc <= pc + 2. inc_pc: pc <= pc + 1. No strobe: pc holds.
- Arithmetic is modulo 2^PC_W: increment from all-ones gives 0; skip from all-ones gives 1, from all-ones minus 1 gives 0. Pushed return address wraps identically.
- Stack is a circular buffer of STACK_DEPTH x PC_W registers indexed by a log2(STACK_DEPTH)-bit pointer; entries are not cleared by reset (contents unspecified until written).
- stack_empty/stack_full are decoded combinationally from the registered stack_count.

## Timing
- All state updates on the rising edge of clk; effect of a command visible on pc and stack outputs the cycle after the strobe is sampled. Latency 1, throughput one command per cycle.
- Back-to-back call/ret are allowed; call followed next cycle by ret returns to the address after the call site.
- Reset (asynchronous, any time, including mid-call/ret): pc = RESET_VEC, stack_count = 0, stack_empty = 1, stack_full = 0, stack_err = 0, pointer = 0. Outputs take reset values immediately, not at the next edge. Commands sampled on the first edge after rst deasserts take effect normally.
- No combinational path from any input to any output.

## Configuration
- Macro PC_STACK_GUARD_EN.
- Defined: call while stack_full is blocked entirely (pc, stack, count unchanged); ret while stack_empty is blocked entirely; either case sets stack_err, which stays 1 until reset. A blocked command does not fall through to lower-priority strobes.
- Undefined: stack wraps. call on full overwrites the oldest entry, count saturates at STACK_DEPTH; ret on empty pops the stale slot below the pointer, count stays 0. stack_err is tied 0.

## Test plan
- Reset/increment: rst pulse with RESET_VEC=3, then inc_pc for 3 cycles -> pc 3,4,5,6; stack_empty=1, stack_err=0.
- Wrap/skip: load load_val=30, then skip -> pc 30 then 0; inc_pc at 31 -> 0.
- Priority: at pc=4 assert load(val 9), skip and inc_pc together -> pc=9; add halt in the same cycle -> pc stays 4.
- Nested call/ret: pc=2, call target 10, then call target 20, then ret, ret -> pc 10, 20, 11, 3; stack_count 1,2,1,0.
- Overflow, PC_STACK_GUARD_EN defined: 5 calls with STACK_DEPTH=4 -> 5th call ignored, pc unchanged, stack_full=1, stack_err=1; undefined -> 5th call taken, count=4, four rets return the last four return addresses.
- Async reset mid-operation: rst asserted between clock edges after two calls -> pc=RESET_VEC, stack_count=0 immediately; following ret with guard defined sets stack_err, pc unchanged.
